memory_dumper: RTL
==================

Name: memory_dumper

Overview:
- Read-side counterpart of the program loader: after execution, reads a contiguous range of data RAM and streams each word out over a valid/ready interface.
- Used by the system for post-run memory inspection and result extraction.
- Sits beside the loader on the RAM port, which the system mux grants to it only in its DUMPING state.
- Single outstanding read; fixed, parameterised RAM read latency.

Parameters:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 16, RAM word width.
- READ_LATENCY, 1, cycles from the mem_read cycle to the mem_read_data sample edge; legal range 1..4.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- base_addr  in  ADDR_WIDTH  first address; sampled when start is accepted.
- length  in  ADDR_WIDTH  number of words; sampled when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the dump completes.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_read  out  1  RAM read strobe; high for exactly one cycle per word.
- mem_read_data  in  DATA_WIDTH  RAM read data.
- out_valid  out  1  stream word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  streamed word.
- out_addr  out  ADDR_WIDTH  address of out_data.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - state goes to IDLE.
  - All outputs are 0: busy, done, mem_read, mem_addr, out_valid, out_data, out_addr.
  - Counters are cleared.
  - A reset mid-dump aborts immediately, with no done pulse.
- States: IDLE, ISSUE, WAIT, SEND, FINISH.
- IDLE:
  - If start is high, latch base_addr into cur_addr and length into remaining.
  - If length == 0, go to FINISH; otherwise go to ISSUE.
- ISSUE (1 cycle):
  - mem_read = 1 and mem_addr = cur_addr.
  - Load wait_cnt = READ_LATENCY - 1, then go to WAIT.
- WAIT:
  - mem_read = 0; mem_addr holds its value.
  - When wait_cnt == 0, capture mem_read_data into out_data and cur_addr into out_addr, then go to SEND.
  - Otherwise decrement wait_cnt.
- SEND:
  - out_valid = 1.
  - out_data and out_addr stay stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle; cur_addr increments; remaining decrements.
  - Then go to FINISH if remaining == 1, otherwise to ISSUE.
- FINISH: done = 1 for one cycle, busy = 1, then go to IDLE.
- Latency:
  - The start edge counts as edge 0.
  - First out_valid rises in cycle READ_LATENCY + 2.
  - With out_ready tied high, the per-word period is READ_LATENCY + 2 cycles.
- Address arithmetic: cur_addr increments modulo 2^ADDR_WIDTH, so 0xFFFF is followed by 0x0000. No error is flagged on wrap.
- length = 2^ADDR_WIDTH - 1 is legal. A full-memory dump is not expressible.
- start while busy is ignored. start sampled in the same cycle that done is high is also ignored.
- out_ready outside SEND has no effect.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- With the macro defined:
  - Adds output checksum, DATA_WIDTH wide.
  - checksum holds the modulo-2^DATA_WIDTH sum of every word accepted on the stream.
  - It is cleared when start is accepted and is valid and stable from the done cycle until the next accepted start.
  - For length 0, checksum = 0.
  - Reset value is 0.
- Without the macro: the checksum port and its adder do not exist, and all other behaviour is identical.

Decomposition:
- Shared package (system_pkg) holds:
  - The state encoding: IDLE=0, ISSUE=1, WAIT=2, SEND=3, FINISH=4; 3 bits.
  - The system-level DUMPING state constant, so the system mux and the bench reference the same values.
- No sub-module: the latency counter and the datapath are small enough to stay inline.

Test Plan:
- Memory preloaded with 0x0010..0x0013 = 0xA001..0xA004; start with base 0x0010, length 4, out_ready=1 -> four beats with out_addr 0x10..0x13 and data A001..A004; first out_valid in cycle 3; done pulses once; busy drops the cycle after done.
- Same dump with out_ready low for 5 cycles on beat 2 -> out_data 0xA002 held stable and no extra mem_read; stream order unchanged.
- length 0 -> no mem_read at all; done in cycle 1.
- base 0xFFFE, length 4 -> out_addr sequence FFFE, FFFF, 0000, 0001.
- reset driven low during beat 2's WAIT -> all outputs 0 next cycle, no done; a subsequent start works normally.
- With DUMP_CHECKSUM_EN, the first scenario -> checksum 0x800A at done (A001+A002+A003+A004 mod 2^16); second start clears it to 0.

Source files
------------

// File: rtl/system_pkg.sv
// system_pkg: state encodings shared by the memory dumper, the system RAM mux and the bench
package system_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        SEND   = 3'd3,
        FINISH = 3'd4
    } dump_state_t;

    // The system mux hands the RAM port to the dumper only while in SYS_DUMPING
    typedef enum logic [1:0] {
        SYS_IDLE    = 2'd0,
        SYS_LOADING = 2'd1,
        SYS_RUNNING = 2'd2,
        SYS_DUMPING = 2'd3
    } sys_state_t;

endpackage

// File: rtl/memory_dumper.sv
// memory_dumper: streams a contiguous RAM range out over valid/ready; DUMP_CHECKSUM_EN adds a running checksum output
module memory_dumper
    import system_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam logic [1:0]            WAIT_LOAD = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(1);

    dump_state_t           state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [1:0]            wait_cnt;

    // Control FSM; every output is registered and set on the transition into the state that owns it
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
        end else begin
            done     <= 1'b0;
            mem_read <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= length;
                        busy      <= 1'b1;
                        if (length == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            mem_read <= 1'b1;
                            mem_addr <= base_addr;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        out_data  <= mem_read_data;
                        out_addr  <= cur_addr;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LAST_WORD) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            mem_read <= 1'b1;
                            mem_addr <= cur_addr + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running sum of accepted beats, cleared on an accepted start and frozen once the dump ends
    always_ff @(posedge clock) begin
        if (!reset) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (state == SEND && out_ready) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule
